spi_slave: RTL and testbench

- Clock-domain SPI slave: the peer that sits directly downstream of spi_master on the SCLK/MOSI/LOAD wires and drives MISO back into it.
- Oversamples the serial inputs with clk, recovers m-bit frames MSB first, and presents each received word with a one-cycle valid pulse.
- Shifts out a word captured at frame start so the master's DO receives it.
- Used as on-chip loopback target and as a template for register-file peripherals.

---
 rtl/spi_slave_if.sv | 31 +++
 rtl/spi_slave.sv | 148 ++++++++++++++
 tb/tb_spi_slave.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_if
//  Purpose  : SPI wires plus the parallel tx/rx word signals of spi_slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_if #(
   parameter int M = 9
);
   logic         SCLK;
   logic         MOSI;
   logic         LOAD;
   logic         MISO;
   logic [M-1:0] tx_data;
   logic         tx_ack;
   logic [M-1:0] rx_data;
   logic         rx_valid;
   logic         frame_err;
   logic         busy;

   modport slave (
      input  SCLK, MOSI, LOAD, tx_data,
      output MISO, tx_ack, rx_data, rx_valid, frame_err, busy
   );

   modport master (
      output SCLK, MOSI, LOAD, tx_data,
      input  MISO, tx_ack, rx_data, rx_valid, frame_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Purpose  : Oversampled SPI slave; receives and transmits M-bit MSB-first frames.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
   parameter int M    = 9,
   parameter int SYNC = 2
) (
   input  wire logic  clk,
   input  wire logic  rst,
   spi_slave_if.slave bus
);
   localparam int            CW     = $clog2(M + 1);
   localparam logic [CW-1:0] c_FULL = CW'(M);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

   logic [SYNC-1:0] r_sclk_sync, r_mosi_sync, r_load_sync, r_arm_pipe;
   logic            r_sclk_prev, r_load_prev, r_armed;
   logic            w_sclk_s, w_mosi_s, w_load_s;
   logic            w_sclk_rise, w_sclk_fall, w_load_rise, w_load_fall;

   state_t          r_state, w_state_nxt;
   logic [M-1:0]    r_tx_sh, w_tx_sh_nxt;
   logic [M-1:0]    r_rx_sh, w_rx_sh_nxt;
   logic [M-1:0]    r_rx_data, w_rx_data_nxt;
   logic [CW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic            r_overflow, w_overflow_nxt;
   logic            r_tx_ack, w_tx_ack_nxt;
   logic            r_rx_valid, w_rx_valid_nxt;
   logic            r_frame_err, w_frame_err_nxt;

   assign w_sclk_s    = r_sclk_sync[SYNC-1];
   assign w_mosi_s    = r_mosi_sync[SYNC-1];
   assign w_load_s    = r_load_sync[SYNC-1];
   assign w_sclk_rise =  w_sclk_s & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk_s &  r_sclk_prev;
   assign w_load_rise =  w_load_s & ~r_load_prev;
   assign w_load_fall = ~w_load_s &  r_load_prev;

   // r_arm_pipe tracks when the LOAD chain holds real pin samples instead of
   // reset values; a frame is only joined after LOAD has been seen idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_load_sync <= '1;
         r_sclk_prev <= 1'b0;
         r_load_prev <= 1'b1;
         r_arm_pipe  <= '0;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC-2:0], bus.SCLK};
         r_mosi_sync <= {r_mosi_sync[SYNC-2:0], bus.MOSI};
         r_load_sync <= {r_load_sync[SYNC-2:0], bus.LOAD};
         r_sclk_prev <= w_sclk_s;
         r_load_prev <= w_load_s;
         r_arm_pipe  <= {r_arm_pipe[SYNC-2:0], 1'b1};
         if (r_arm_pipe[SYNC-1] && w_load_s) begin
            r_armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_tx_sh     <= '0;
         r_rx_sh     <= '0;
         r_rx_data   <= '0;
         r_bit_cnt   <= '0;
         r_overflow  <= 1'b0;
         r_tx_ack    <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tx_sh     <= w_tx_sh_nxt;
         r_rx_sh     <= w_rx_sh_nxt;
         r_rx_data   <= w_rx_data_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_overflow  <= w_overflow_nxt;
         r_tx_ack    <= w_tx_ack_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_tx_sh_nxt     = r_tx_sh;
      w_rx_sh_nxt     = r_rx_sh;
      w_rx_data_nxt   = r_rx_data;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_overflow_nxt  = r_overflow;
      w_tx_ack_nxt    = 1'b0;
      w_rx_valid_nxt  = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_load_fall && r_armed) begin
               w_tx_sh_nxt    = bus.tx_data;
               w_tx_ack_nxt   = 1'b1;
               w_rx_sh_nxt    = '0;
               w_bit_cnt_nxt  = '0;
               w_overflow_nxt = 1'b0;
               w_state_nxt    = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (w_sclk_rise) begin
               w_rx_sh_nxt = {r_rx_sh[M-2:0], w_mosi_s};
               if (r_bit_cnt < c_FULL) begin
                  w_bit_cnt_nxt = r_bit_cnt + 1'b1;
               end else begin
                  w_overflow_nxt = 1'b1;
               end
            end
            // Once M bits are out the shifter freezes, so MISO holds its last bit.
            if (w_sclk_fall && (r_bit_cnt < c_FULL)) begin
               w_tx_sh_nxt = {r_tx_sh[M-2:0], 1'b0};
            end
            // Evaluated on the post-update count so a coincident last SCLK rise is counted.
            if (w_load_rise) begin
               w_state_nxt = S_IDLE;
               if ((w_bit_cnt_nxt == c_FULL) && !w_overflow_nxt) begin
                  w_rx_data_nxt  = w_rx_sh_nxt;
                  w_rx_valid_nxt = 1'b1;
               end else begin
                  w_frame_err_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // MISO is the shifter MSB while a frame is active and 0 otherwise.
   assign bus.MISO      = r_tx_sh[M-1] & (r_state == S_ACTIVE);
   assign bus.tx_ack    = r_tx_ack;
   assign bus.rx_data   = r_rx_data;
   assign bus.rx_valid  = r_rx_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.busy      = (r_state == S_ACTIVE);
endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Purpose  : Directed self-checking bench for spi_slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;
   localparam int M    = 9;
   localparam int SYNC = 2;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0, n_rxv = 0, n_ack = 0, n_ferr = 0, ack_cyc = 0;

   spi_slave_if #(.M(M)) bus ();
   spi_slave #(.M(M), .SYNC(SYNC)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_valid)  n_rxv  <= n_rxv + 1;
      if (bus.frame_err) n_ferr <= n_ferr + 1;
      if (bus.tx_ack) begin
         n_ack   <= n_ack + 1;
         ack_cyc <= cyc;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame(input logic [M-1:0] tx, output int fall_cyc);
      bus.tx_data = tx;
      @(negedge clk);
      bus.LOAD = 1'b0;
      fall_cyc = cyc;
   endtask

   task automatic pulse(input logic b, output logic mi);
      bus.MOSI = b;
      idle(HALF);
      bus.SCLK = 1'b1;
      mi = bus.MISO;
      idle(HALF);
      bus.SCLK = 1'b0;
   endtask

   task automatic send_bits(input logic [M-1:0] word, input int n, output logic [M-1:0] mw);
      logic mi;
      mw = '0;
      for (int i = 0; i < n; i++) begin
         pulse((i < M) ? word[M-1-i] : 1'b0, mi);
         if (i < M) mw = {mw[M-2:0], mi};
      end
   endtask

   task automatic end_frame;
      idle(HALF);
      bus.LOAD = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(3);
      checks++;
      if ({bus.MISO, bus.tx_ack, bus.rx_valid, bus.frame_err, bus.busy} !== 5'b0)
         $display("FAIL reset_flags: got %b expected 00000",
                  {bus.MISO, bus.tx_ack, bus.rx_valid, bus.frame_err, bus.busy});
      checks++;
      if (bus.rx_data !== 9'h000)
         $display("FAIL reset_rx_data: got %h expected 000", bus.rx_data);
      if ({bus.MISO, bus.tx_ack, bus.rx_valid, bus.frame_err, bus.busy} !== 5'b0) errors++;
      if (bus.rx_data !== 9'h000) errors++;
      rst = 1'b0;
      idle(10);
   endtask

   task automatic test_basic;
      logic [M-1:0] mw;
      int fc, rxv0, ack0, fe0;
      rxv0 = n_rxv; ack0 = n_ack; fe0 = n_ferr;
      start_frame(9'h1A5, fc);
      send_bits(9'h0F3, 9, mw);
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
      checks++;
      if (mw !== 9'h1A5) begin errors++; $display("FAIL basic_miso: got %h expected 1a5", mw); end
      checks++;
      if (ack_cyc - fc !== 3) begin errors++; $display("FAIL basic_ack_lat: got %0d expected 3", ack_cyc - fc); end
      end_frame;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (bus.rx_valid !== (k == 3)) begin
            errors++;
            $display("FAIL basic_rxv_t%0d: got %b expected %b", k, bus.rx_valid, (k == 3));
         end
      end
      idle(4);
      checks++;
      if (bus.rx_data !== 9'h0F3) begin errors++; $display("FAIL basic_rx_data: got %h expected 0f3", bus.rx_data); end
      checks++;
      if ({n_rxv - rxv0, n_ack - ack0, n_ferr - fe0} !== {32'd1, 32'd1, 32'd0}) begin
         errors++;
         $display("FAIL basic_counts: got rxv=%0d ack=%0d ferr=%0d expected 1 1 0",
                  n_rxv - rxv0, n_ack - ack0, n_ferr - fe0);
      end
      checks++;
      if ({bus.busy, bus.MISO} !== 2'b00) begin errors++; $display("FAIL basic_idle: got busy,miso=%b expected 00", {bus.busy, bus.MISO}); end
   endtask

   task automatic test_back_to_back;
      logic [M-1:0] mw1, mw2;
      int fc, rxv0;
      rxv0 = n_rxv;
      start_frame(9'h0AA, fc);
      send_bits(9'h1FF, 9, mw1);
      end_frame;
      idle(8);
      checks++;
      if (bus.rx_data !== 9'h1FF) begin errors++; $display("FAIL b2b_rx1: got %h expected 1ff", bus.rx_data); end
      idle(8);
      start_frame(9'h155, fc);
      send_bits(9'h000, 9, mw2);
      end_frame;
      idle(8);
      checks++;
      if (bus.rx_data !== 9'h000) begin errors++; $display("FAIL b2b_rx2: got %h expected 000", bus.rx_data); end
      checks++;
      if ({mw1, mw2} !== {9'h0AA, 9'h155}) begin errors++; $display("FAIL b2b_miso: got %h %h expected 0aa 155", mw1, mw2); end
      checks++;
      if (n_rxv - rxv0 !== 2) begin errors++; $display("FAIL b2b_rxv_count: got %0d expected 2", n_rxv - rxv0); end
   endtask

   task automatic test_short;
      logic [M-1:0] mw;
      int fc, rxv0, fe0;
      rxv0 = n_rxv; fe0 = n_ferr;
      start_frame(9'h111, fc);
      send_bits(9'h0C3, 7, mw);
      end_frame;
      idle(8);
      checks++;
      if ({n_ferr - fe0, n_rxv - rxv0} !== {32'd1, 32'd0}) begin
         errors++;
         $display("FAIL short_counts: got ferr=%0d rxv=%0d expected 1 0", n_ferr - fe0, n_rxv - rxv0);
      end
      checks++;
      if (bus.rx_data !== 9'h000) begin errors++; $display("FAIL short_rx_hold: got %h expected 000", bus.rx_data); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_long;
      logic [M-1:0] mw;
      logic m10, m11;
      int fc, rxv0, fe0;
      rxv0 = n_rxv; fe0 = n_ferr;
      start_frame(9'h0B7, fc);
      send_bits(9'h1C7, 9, mw);
      pulse(1'b0, m10);
      pulse(1'b0, m11);
      end_frame;
      idle(8);
      checks++;
      if ({mw, m10, m11} !== {9'h0B7, 2'b11}) begin
         errors++;
         $display("FAIL long_miso: got %h %b%b expected 0b7 11", mw, m10, m11);
      end
      checks++;
      if ({n_ferr - fe0, n_rxv - rxv0} !== {32'd1, 32'd0}) begin
         errors++;
         $display("FAIL long_counts: got ferr=%0d rxv=%0d expected 1 0", n_ferr - fe0, n_rxv - rxv0);
      end
      checks++;
      if (bus.rx_data !== 9'h000) begin errors++; $display("FAIL long_rx_hold: got %h expected 000", bus.rx_data); end
      idle(16);
      rxv0 = n_rxv;
      start_frame(9'h000, fc);
      send_bits(9'h055, 9, mw);
      end_frame;
      idle(8);
      checks++;
      if (bus.rx_data !== 9'h055) begin errors++; $display("FAIL long_next_rx: got %h expected 055", bus.rx_data); end
      checks++;
      if (n_rxv - rxv0 !== 1) begin errors++; $display("FAIL long_next_rxv: got %0d expected 1", n_rxv - rxv0); end
   endtask

   task automatic test_reset_mid;
      logic [M-1:0] mw;
      logic mi;
      logic [M-1:0] word;
      int fc, rxv0, fe0, ack0;
      word = 9'h0AB;
      start_frame(9'h1E1, fc);
      for (int i = 0; i < 4; i++) pulse(word[M-1-i], mi);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({bus.busy, bus.MISO, bus.tx_ack, bus.rx_valid, bus.frame_err} !== 5'b0) begin
         errors++;
         $display("FAIL rstmid_flags: got %b expected 00000",
                  {bus.busy, bus.MISO, bus.tx_ack, bus.rx_valid, bus.frame_err});
      end
      checks++;
      if (bus.rx_data !== 9'h000) begin errors++; $display("FAIL rstmid_rx_data: got %h expected 000", bus.rx_data); end
      idle(1);
      rxv0 = n_rxv; fe0 = n_ferr; ack0 = n_ack;
      for (int i = 4; i < M; i++) pulse(word[M-1-i], mi);
      end_frame;
      idle(8);
      checks++;
      if ({n_rxv - rxv0, n_ferr - fe0, n_ack - ack0} !== {32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL rstmid_quiet: got rxv=%0d ferr=%0d ack=%0d expected 0 0 0",
                  n_rxv - rxv0, n_ferr - fe0, n_ack - ack0);
      end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
      idle(8);
      start_frame(9'h033, fc);
      send_bits(9'h12C, 9, mw);
      end_frame;
      idle(8);
      checks++;
      if ({bus.rx_data, mw} !== {9'h12C, 9'h033}) begin
         errors++;
         $display("FAIL rstmid_next: got rx=%h miso=%h expected 12c 033", bus.rx_data, mw);
      end
   endtask

   task automatic test_same_cycle;
      logic [M-1:0] mw;
      logic [M-1:0] word;
      int fc, rxv0, fe0;
      word = 9'h16A;
      rxv0 = n_rxv; fe0 = n_ferr;
      start_frame(9'h0F0, fc);
      send_bits(word, 8, mw);
      bus.MOSI = word[0];
      idle(HALF);
      bus.SCLK = 1'b1;
      bus.LOAD = 1'b1;
      idle(HALF);
      bus.SCLK = 1'b0;
      idle(8);
      checks++;
      if (mw !== 9'h078) begin errors++; $display("FAIL same_miso: got %h expected 078", mw); end
      checks++;
      if ({n_rxv - rxv0, n_ferr - fe0} !== {32'd1, 32'd0}) begin
         errors++;
         $display("FAIL same_counts: got rxv=%0d ferr=%0d expected 1 0", n_rxv - rxv0, n_ferr - fe0);
      end
      checks++;
      if (bus.rx_data !== 9'h16A) begin errors++; $display("FAIL same_rx_data: got %h expected 16a", bus.rx_data); end
   endtask

   initial begin
      bus.SCLK    = 1'b0;
      bus.MOSI    = 1'b0;
      bus.LOAD    = 1'b1;
      bus.tx_data = '0;
      test_reset;
      test_basic;
      idle(8);
      test_back_to_back;
      idle(8);
      test_short;
      idle(8);
      test_long;
      idle(8);
      test_reset_mid;
      idle(8);
      test_same_cycle;
      idle(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
